ws2812b_rx: RTL and testbench
=============================

Name: ws2812b_rx

Overview:
- Memory-mapped WS2812B receiver/decoder. It is the counterpart to the team's WS2812B transmitter peripheral.
- Samples a single-wire WS2812B data line, classifies each high pulse as 0 or 1, assembles 24-bit GRB words, and presents them to the softcore as {R,G,B}. This is the same byte packing software uses when writing the transmitter.
- Used for loopback self-test of the LED output and for sniffing an LED chain.

Parameters:
- ADDR, 32'h0000_0000, bus address of the single data/status register.
- CLK_FREQ, 12e6, clk frequency in Hz. All timing constants derive from it, each rounded as $rtoi(CLK_FREQ*t + 0.5):
  - THRESH (t = 0.60 us), high-time split between 0 and 1.
  - MIN_H (t = 0.15 us), shortest legal high pulse.
  - MAX_H (t = 1.20 us), longest legal high pulse.
  - IDLE_LOW (t = 50 us), low time that marks the end of a frame.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- mem_valid  input  1  bus request
- mem_addr  input  32  bus address
- mem_wstrb  input  4  byte write strobes; 0 means read
- mem_wdata  input  32  write data (ignored)
- mem_rdata  output  32  registered read data
- mem_ready  output  1  one-cycle acknowledge
- din  input  1  asynchronous WS2812B serial line
- irq  output  1  level; equals the VALID flag

Behaviour:
- Reset: one clk, single domain, synchronous active-high.
  - mem_rdata=0, mem_ready=0, irq=0.
  - Flags clear; shift register, bit count and counter = 0.
  - State = SYNC.
  - Reset asserted mid-frame discards the partial word.
- Input synchronisation: din passes through a 2-FF synchroniser. All timing uses the synchronised level (2-cycle latency); edges are detected on it.
- Counter: 16 bits, saturating, cleared on every synchronised edge.
- FSM:
  - SYNC: wait for IDLE_LOW consecutive low cycles, then go to LOW. A rising edge restarts the count.
  - LOW: on rising edge, go to HIGH. If the low count reaches IDLE_LOW, the frame ends: bitcnt nonzero sets ERR, then bitcnt=0. Stay in LOW.
  - HIGH: on falling edge, let h = counter+1 (high-cycle count).
    - h < MIN_H: glitch. Set ERR, bitcnt=0, go to SYNC.
    - MIN_H <= h < THRESH: shift in 0, go to LOW.
    - THRESH <= h <= MAX_H: shift in 1, go to LOW.
    - If the counter passes MAX_H while still high: set ERR, bitcnt=0, go to SYNC (without waiting for the fall).
- Word assembly:
  - Bits shift in MSB-first into sh[23:0]; the first wire bit lands in sh[23].
  - On the 24th bit: DATA = {sh[15:8], sh[23:16], sh[7:0]} (R,G,B), including the bit just decoded. bitcnt=0.
  - If VALID was already 1, set OVR. Then set VALID (DATA is overwritten).
  - Decoding continues; the next 24 bits form the next word.
- Register read format: {VALID, OVR, ERR, 5'b0, DATA[23:0]}.
- Bus access:
  - An access is accepted when mem_valid && mem_addr==ADDR && !mem_ready.
  - Next cycle: mem_ready=1 for exactly one cycle.
  - Read (mem_wstrb==0): mem_rdata = register snapshot from the accept cycle; VALID, OVR and ERR clear.
  - Write (any strobe): VALID, OVR and ERR clear; mem_rdata=0.
  - Cycles without an accepted access: mem_rdata=0, mem_ready=0.
- Simultaneous events: if a word completes in the accept cycle, the read returns the pre-update snapshot. The flag set wins over the clear, so VALID=1 afterwards (OVR likewise). The same rule applies to ERR.
- Arithmetic: bitcnt is 5 bits and counts 0..23. Threshold comparisons are unsigned, using 16-bit widths.

Test Plan:
- Reset release, din low for 600 cycles, then frame G=0x12 R=0x34 B=0x56 (T0H 5, T1H 10, lows 10/5 cycles) -> VALID=1, irq=1; read returns 32'h8034_1256; a second read returns 32'h0034_1256, irq=0.
- Two back-to-back 24-bit words with no read between, second word R,G,B = 0xFF,0x00,0xAA -> read returns 32'hC0FF_00AA.
- Frame of 12 bits, then 600 low cycles -> ERR set; read returns bit29=1, VALID=0; next full frame decodes correctly.
- High pulse of 1 cycle mid-frame (after the 2-FF) -> ERR; block resyncs only after 600 low cycles; a frame sent 100 cycles later is ignored until the idle period has elapsed.
- High held 20 cycles -> ERR without waiting for the falling edge; state SYNC.
- 24th bit decoded in the same cycle a read is accepted -> read returns old flags; VALID=1 afterwards; mem_ready high for exactly one cycle while mem_valid is held three cycles.

Source files
------------

// File: rtl/ws2812b_rx.sv
// WS2812B line decoder: times high pulses, assembles 24-bit GRB words and shows them as {R,G,B} with flags in one register.
// Latency: 2-cycle input sync, word visible one cycle after its last falling edge is seen; bus ack one cycle after accept.
// Backpressure: none on the line; an unread word is overwritten and flagged as overrun.
module ws2812b_rx #(
    parameter logic [31:0] ADDR     = 32'h0000_0000,
    parameter real         CLK_FREQ = 12e6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    input  logic        din,
    output logic        irq
);

    localparam int THRESH_I   = $rtoi(CLK_FREQ * 0.60e-6 + 0.5);
    localparam int MIN_H_I    = $rtoi(CLK_FREQ * 0.15e-6 + 0.5);
    localparam int MAX_H_I    = $rtoi(CLK_FREQ * 1.20e-6 + 0.5);
    localparam int IDLE_LOW_I = $rtoi(CLK_FREQ * 50.0e-6 + 0.5);

    localparam logic [15:0] THRESH  = 16'(THRESH_I);
    localparam logic [15:0] MIN_H   = 16'(MIN_H_I);
    localparam logic [15:0] MAX_H   = 16'(MAX_H_I);
    localparam logic [15:0] MAX_M1  = 16'(MAX_H_I - 1);
    localparam logic [15:0] IDLE_M1 = 16'(IDLE_LOW_I - 1);

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        din_m;
    logic        din_s;
    logic        din_d;
    logic        rise;
    logic        fall;
    logic        edge_det;
    logic [15:0] cnt;
    logic [15:0] h;
    logic [4:0]  bitcnt;
    logic [23:0] sh;
    logic [23:0] sh_n;
    logic [23:0] data;
    logic        valid_f;
    logic        ovr_f;
    logic        err_f;
    logic        bit_ev;
    logic        bit_val;
    logic        err_ev;
    logic        frame_end;
    logic        word_done;
    logic        err_set;
    logic        accept;
    logic        unused_ok;

    assign rise      = din_s & ~din_d;
    assign fall      = ~din_s & din_d;
    assign edge_det  = din_s ^ din_d;
    // cnt holds the number of cycles the level has been stable before the current one
    assign h         = cnt + 16'd1;
    assign sh_n      = {sh[22:0], bit_val};
    assign word_done = bit_ev && (bitcnt == 5'd23);
    assign err_set   = err_ev || (frame_end && (bitcnt != 5'd0));
    assign accept    = mem_valid && (mem_addr == ADDR) && !mem_ready;
    assign irq       = valid_f;
    assign unused_ok = ^mem_wdata;

    always_comb begin
        state_n   = state;
        bit_ev    = 1'b0;
        bit_val   = 1'b0;
        err_ev    = 1'b0;
        frame_end = 1'b0;
        case (state)
            SYNC: begin
                if (!din_s && !din_d && (cnt >= IDLE_M1)) begin
                    state_n = LOW;
                end
            end
            LOW: begin
                if (!din_d && (cnt == IDLE_M1)) begin
                    frame_end = 1'b1;
                end
                if (rise) begin
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if ((h < MIN_H) || (h > MAX_H)) begin
                        err_ev  = 1'b1;
                        state_n = SYNC;
                    end else begin
                        bit_ev  = 1'b1;
                        bit_val = (h >= THRESH);
                        state_n = LOW;
                    end
                end else if (cnt >= MAX_M1) begin
                    // line still high with more than MAX_H cycles already seen
                    err_ev  = 1'b1;
                    state_n = SYNC;
                end
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            din_m     <= 1'b0;
            din_s     <= 1'b0;
            din_d     <= 1'b0;
            cnt       <= 16'd0;
            state     <= SYNC;
            bitcnt    <= 5'd0;
            sh        <= 24'd0;
            data      <= 24'd0;
            valid_f   <= 1'b0;
            ovr_f     <= 1'b0;
            err_f     <= 1'b0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;

            if (edge_det) begin
                cnt <= 16'd0;
            end else if (cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end

            state <= state_n;

            if (err_ev || frame_end) begin
                bitcnt <= 5'd0;
            end else if (bit_ev) begin
                sh <= sh_n;
                if (bitcnt == 5'd23) begin
                    bitcnt <= 5'd0;
                    data   <= {sh_n[15:8], sh_n[23:16], sh_n[7:0]};
                end else begin
                    bitcnt <= bitcnt + 5'd1;
                end
            end

            // a flag raised in the accept cycle survives the clear
            valid_f <= word_done | (valid_f & ~accept);
            ovr_f   <= (word_done & valid_f) | (ovr_f & ~accept);
            err_f   <= err_set | (err_f & ~accept);

            mem_ready <= accept;
            if (accept && (mem_wstrb == 4'd0)) begin
                mem_rdata <= {valid_f, ovr_f, err_f, 5'd0, data};
            end else begin
                mem_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Bench for ws2812b_rx: vector table, directed corner sequences and randomized frames checked against a word-level model.
module tb_ws2812b_rx;

    localparam logic [31:0] ADDR = 32'h0000_0000;
    localparam int          IDLE = 620;

    typedef struct {
        logic [23:0] grb;
        int          h0;
        int          h1;
        int          lo;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        din;
    logic        irq;

    int checks = 0;
    int errors = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    ws2812b_rx #(.ADDR(ADDR), .CLK_FREQ(12e6)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .din(din), .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Register view of a wire word: G first on the wire, software sees R,G,B.
    function automatic logic [23:0] grb2reg(input logic [23:0] w);
        int g, r, b;
        g = (int'(w) >> 16) & 255;
        r = (int'(w) >> 8) & 255;
        b = int'(w) & 255;
        return 24'((r << 16) | (g << 8) | b);
    endfunction

    task automatic send_bit(input logic b, input int th, input int tl);
        din = 1'b1;
        repeat (th) tick();
        din = 1'b0;
        repeat (tl) tick();
    endtask

    // Sends the top n bits of w, MSB first.
    task automatic send_bits(input logic [23:0] w, input int n, input int h0, input int h1, input int l0, input int l1);
        for (int i = 23; i >= 24 - n; i--) begin
            if (w[i]) send_bit(1'b1, h1, l1);
            else      send_bit(1'b0, h0, l0);
        end
    endtask

    task automatic send_rand_bits(input logic [23:0] w, input int n);
        for (int i = 23; i >= 24 - n; i--) begin
            if (w[i]) send_bit(1'b1, int'($urandom_range(7, 14)), int'($urandom_range(2, 12)));
            else      send_bit(1'b0, int'($urandom_range(2, 6)), int'($urandom_range(2, 12)));
        end
    endtask

    task automatic bus_rd(input string name, input logic [31:0] exp);
        int n;
        mem_addr  = ADDR;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        tick();
        n = 0;
        while (!mem_ready && n < 8) begin
            tick();
            n++;
        end
        mem_valid = 1'b0;
        chk({name, "_ack"}, 32'(mem_ready), 32'h1);
        chk(name, mem_rdata, exp);
        tick();
    endtask

    task automatic bus_wr(input string name);
        int n;
        mem_addr  = ADDR;
        mem_wstrb = 4'hF;
        mem_wdata = $urandom;
        mem_valid = 1'b1;
        tick();
        n = 0;
        while (!mem_ready && n < 8) begin
            tick();
            n++;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        chk({name, "_ack"}, 32'(mem_ready), 32'h1);
        chk({name, "_rdata"}, mem_rdata, 32'h0);
        tick();
    endtask

    task automatic rand_frames(input int iters);
        logic [23:0] q[$];
        logic [23:0] w;
        logic [31:0] exp;
        int nw, extra;
        for (int it = 0; it < iters; it++) begin
            q.delete();
            nw    = int'($urandom_range(1, 3));
            extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 23)) : 0;
            for (int k = 0; k < nw; k++) begin
                w = 24'($urandom);
                q.push_back(w);
                send_rand_bits(w, 24);
            end
            if (extra > 0) begin
                send_rand_bits(24'($urandom), extra);
                repeat (IDLE) tick();
            end else begin
                repeat (5) tick();
            end
            exp = {1'b1, (q.size() > 1), (extra > 0), 5'b0, grb2reg(q[q.size() - 1])};
            chk("rand_irq", 32'(irq), 32'h1);
            bus_rd("rand_read", exp);
        end
    endtask

    initial begin
        vecs[0] = '{24'h123456, 2, 14, 2, 32'h8034_1256};
        vecs[1] = '{24'hA5C33C, 6, 7, 3, 32'h80C3_A53C};
        vecs[2] = '{24'hFFFFFF, 5, 14, 20, 32'h80FF_FFFF};
        vecs[3] = '{24'h000000, 2, 10, 8, 32'h8000_0000};
        vecs[4] = '{24'h010203, 4, 9, 4, 32'h8002_0103};
        vecs[5] = '{24'h00FFAA, 6, 7, 2, 32'h80FF_00AA};

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = ADDR;
        mem_wstrb = 4'h0;
        mem_wdata = 32'h0;
        din       = 1'b0;
        repeat (3) tick();
        chk("reset_rdata", mem_rdata, 32'h0);
        chk("reset_ready", 32'(mem_ready), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        repeat (IDLE) tick();

        // basic frame and read-clears
        send_bits(24'h123456, 24, 5, 10, 10, 5);
        repeat (4) tick();
        chk("frame_irq", 32'(irq), 32'h1);
        bus_rd("frame_read", 32'h8034_1256);
        bus_rd("frame_reread", 32'h0034_1256);
        chk("frame_irq_clr", 32'(irq), 32'h0);

        // two words without a read: overrun
        send_bits(24'h5A5A5A, 24, 5, 10, 10, 5);
        send_bits(24'h00FFAA, 24, 5, 10, 10, 5);
        repeat (4) tick();
        bus_rd("ovr_read", 32'hC0FF_00AA);

        // vector table: boundary pulse widths and byte packing
        for (int i = 0; i < 6; i++) begin
            send_bits(vecs[i].grb, 24, vecs[i].h0, vecs[i].h1, vecs[i].lo, vecs[i].lo);
            repeat (4) tick();
            bus_rd("vec_read", vecs[i].exp);
            chk("vec_irq_clr", 32'(irq), 32'h0);
        end

        // short frame ended by idle
        send_bits(24'hABC000, 12, 5, 10, 6, 6);
        repeat (IDLE) tick();
        bus_rd("short_read", 32'h20FF_00AA);
        send_bits(24'h123456, 24, 5, 10, 6, 6);
        repeat (4) tick();
        bus_rd("short_next", 32'h8034_1256);

        // glitch mid-frame, frame 100 cycles later must be ignored
        send_bits(24'hFFFFFF, 5, 5, 10, 6, 6);
        din = 1'b1;
        tick();
        din = 1'b0;
        repeat (100) tick();
        send_bits(24'h00FFAA, 24, 5, 10, 6, 6);
        repeat (4) tick();
        bus_rd("glitch_read", 32'h2034_1256);
        repeat (IDLE) tick();
        send_bits(24'h010203, 24, 5, 10, 6, 6);
        repeat (4) tick();
        bus_rd("glitch_resync", 32'h8002_0103);

        // stuck-high line flags before the fall, then waits for idle
        din = 1'b1;
        repeat (20) tick();
        bus_rd("long_high", 32'h2002_0103);
        din = 1'b0;
        repeat (10) tick();
        send_bits(24'hFFFFFF, 24, 5, 10, 6, 6);
        repeat (4) tick();
        bus_rd("long_ignored", 32'h0002_0103);
        repeat (IDLE) tick();

        // 24th bit decoded in the accept cycle
        send_bits(24'h123456, 24, 5, 10, 6, 6);
        repeat (4) tick();
        chk("coinc_pre_irq", 32'(irq), 32'h1);
        send_bits(24'hA5C33C, 23, 5, 10, 6, 6);
        din = 1'b1;
        repeat (5) tick();
        din = 1'b0;
        tick();
        tick();
        mem_addr  = ADDR;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        tick();
        chk("coinc_ready1", 32'(mem_ready), 32'h1);
        chk("coinc_rdata", mem_rdata, 32'h8034_1256);
        tick();
        chk("coinc_ready2", 32'(mem_ready), 32'h0);
        mem_valid = 1'b0;
        chk("coinc_irq", 32'(irq), 32'h1);
        bus_rd("coinc_after", 32'hC0C3_A53C);
        bus_rd("coinc_clear", 32'h00C3_A53C);

        // write clears flags
        send_bits(24'h010203, 24, 5, 10, 6, 6);
        repeat (4) tick();
        chk("wr_pre_irq", 32'(irq), 32'h1);
        bus_wr("wr");
        chk("wr_irq", 32'(irq), 32'h0);
        bus_rd("wr_read", 32'h0002_0103);

        // other addresses are not acknowledged
        mem_addr  = ADDR + 32'h4;
        mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bad_addr_ready", 32'(mem_ready), 32'h0);
        end
        mem_valid = 1'b0;
        mem_addr  = ADDR;

        // reset mid-frame drops the partial word
        send_bits(24'hF0F000, 12, 5, 10, 6, 6);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("midrst_irq", 32'(irq), 32'h0);
        chk("midrst_rdata", mem_rdata, 32'h0);
        repeat (IDLE) tick();
        send_bits(24'hA5C33C, 24, 5, 10, 6, 6);
        repeat (4) tick();
        bus_rd("midrst_read", 32'h80C3_A53C);

        rand_frames(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
